// File: rtl/semaphore_pkg.sv
// Shared types and default sizing for the counting-semaphore engine.
package semaphore_pkg;

  localparam int NUM_SEM_DEF  = 4;
  localparam int CNT_W_DEF    = 8;
  localparam int NUM_TASK_DEF = 16;

  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,
    OP_TAKE  = 2'd1,
    OP_GIVE  = 2'd2,
    OP_QUERY = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_BLOCKED  = 2'd1,
    ST_OVERFLOW = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2,
    S_WAKE = 2'd3
  } state_e;

endpackage

// File: rtl/semaphore_prio_enc.sv
// Lowest-set-bit encoder over a waiter mask; lower task IDs are released first.
module semaphore_prio_enc #(
  parameter int NUM_TASK = 16,
  parameter int IDX_W    = 4
) (
  input  logic [NUM_TASK-1:0] mask,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = NUM_TASK - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/semaphore_core.sv
// Counting semaphores with waiter masks; one command in flight through IDLE/EXEC/RESP/WAKE.
module semaphore_core
  import semaphore_pkg::*;
#(
  parameter  int NUM_SEM  = NUM_SEM_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int NUM_TASK = NUM_TASK_DEF,
  localparam int SEM_W    = (NUM_SEM > 1) ? $clog2(NUM_SEM) : 1,
  localparam int TASK_W   = (NUM_TASK > 1) ? $clog2(NUM_TASK) : 1
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEM_W-1:0]  cmd_sem,
  input  logic [TASK_W-1:0] cmd_task,
  input  logic [CNT_W-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [CNT_W-1:0]  rsp_count,
  output logic              wake_valid,
  input  logic              wake_ready,
  output logic [TASK_W-1:0] wake_task,
  output logic [SEM_W-1:0]  wake_sem,
  output logic              irq,
  input  logic              irq_ack
);

  state_e              state_r;
  state_e              state_nx_s;

  op_e                 op_r;
  logic [SEM_W-1:0]    sem_r;
  logic [TASK_W-1:0]   task_r;
  logic [CNT_W-1:0]    data_r;

  logic [CNT_W-1:0]    count_r   [NUM_SEM];
  logic [CNT_W-1:0]    max_r     [NUM_SEM];
  logic [NUM_TASK-1:0] waiters_r [NUM_SEM];

  status_e             rsp_status_r;
  logic [CNT_W-1:0]    rsp_count_r;
  logic                handoff_r;
  logic [TASK_W-1:0]   wake_task_r;
  logic [SEM_W-1:0]    wake_sem_r;
  logic                irq_r;

  logic [CNT_W-1:0]    cur_count_s;
  logic [CNT_W-1:0]    cur_max_s;
  logic [NUM_TASK-1:0] cur_wait_s;
  logic [NUM_TASK-1:0] task_bit_s;
  logic [TASK_W-1:0]   low_idx_s;
  logic                found_s;
  logic [CNT_W-1:0]    count_nx_s;
  logic [CNT_W-1:0]    max_nx_s;
  logic [NUM_TASK-1:0] wait_nx_s;
  status_e             status_s;
  logic                handoff_s;
  logic                wake_fire_s;

  assign cur_count_s = count_r[sem_r];
  assign cur_max_s   = max_r[sem_r];
  assign cur_wait_s  = waiters_r[sem_r];
  assign task_bit_s  = {{(NUM_TASK-1){1'b0}}, 1'b1} << task_r;
  assign wake_fire_s = (state_r == S_WAKE) && wake_ready;

  semaphore_prio_enc #(
    .NUM_TASK (NUM_TASK),
    .IDX_W    (TASK_W)
  ) u_prio_enc (
    .mask  (cur_wait_s),
    .idx   (low_idx_s),
    .found (found_s)
  );

  // Operation result for the latched command, committed during EXEC.
  always_comb begin
    count_nx_s = cur_count_s;
    max_nx_s   = cur_max_s;
    wait_nx_s  = cur_wait_s;
    status_s   = ST_OK;
    handoff_s  = 1'b0;
    case (op_r)
      OP_INIT: begin
        count_nx_s = data_r;
        max_nx_s   = data_r;
        wait_nx_s  = {NUM_TASK{1'b0}};
      end
      OP_TAKE: begin
        if (cur_count_s != {CNT_W{1'b0}}) begin
          count_nx_s = cur_count_s - CNT_W'(1'b1);
        end else begin
          wait_nx_s = cur_wait_s | task_bit_s;
          status_s  = ST_BLOCKED;
        end
      end
      OP_GIVE: begin
        // A waiting task takes the unit directly, so the count stays put.
        if (found_s) begin
          wait_nx_s = cur_wait_s & ~({{(NUM_TASK-1){1'b0}}, 1'b1} << low_idx_s);
          handoff_s = 1'b1;
        end else if (cur_count_s < cur_max_s) begin
          count_nx_s = cur_count_s + CNT_W'(1'b1);
        end else begin
          status_s = ST_OVERFLOW;
        end
      end
      OP_QUERY: begin
        status_s = ST_OK;
      end
      default: begin
        status_s = ST_OK;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) state_nx_s = S_EXEC;
        else           state_nx_s = S_IDLE;
      end
      S_EXEC: state_nx_s = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_nx_s = handoff_r ? S_WAKE : S_IDLE;
        else           state_nx_s = S_RESP;
      end
      S_WAKE: begin
        if (wake_ready) state_nx_s = S_IDLE;
        else            state_nx_s = S_WAKE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM handshake outputs, held low while reset is asserted.
  always_comb begin
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    wake_valid = 1'b0;
    if (!ARESET) begin
      case (state_r)
        S_IDLE:  cmd_ready  = 1'b1;
        S_RESP:  rsp_valid  = 1'b1;
        S_WAKE:  wake_valid = 1'b1;
        default: cmd_ready  = 1'b0;
      endcase
    end else begin
      cmd_ready = 1'b0;
    end
  end

  // Command capture, per-semaphore state, response/wake registers and irq.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      op_r         <= OP_QUERY;
      sem_r        <= {SEM_W{1'b0}};
      task_r       <= {TASK_W{1'b0}};
      data_r       <= {CNT_W{1'b0}};
      for (int s = 0; s < NUM_SEM; s++) begin
        count_r[s]   <= {CNT_W{1'b0}};
        max_r[s]     <= {CNT_W{1'b0}};
        waiters_r[s] <= {NUM_TASK{1'b0}};
      end
      rsp_status_r <= ST_OK;
      rsp_count_r  <= {CNT_W{1'b0}};
      handoff_r    <= 1'b0;
      wake_task_r  <= {TASK_W{1'b0}};
      wake_sem_r   <= {SEM_W{1'b0}};
      irq_r        <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && cmd_valid) begin
        op_r   <= op_e'(cmd_op);
        sem_r  <= cmd_sem;
        task_r <= cmd_task;
        data_r <= cmd_data;
      end
      if (state_r == S_EXEC) begin
        count_r[sem_r]   <= count_nx_s;
        max_r[sem_r]     <= max_nx_s;
        waiters_r[sem_r] <= wait_nx_s;
        rsp_status_r     <= status_s;
        rsp_count_r      <= count_nx_s;
        handoff_r        <= handoff_s;
        if (handoff_s) begin
          wake_task_r <= low_idx_s;
          wake_sem_r  <= sem_r;
        end
      end
      // A wake handshake beats a simultaneous acknowledge.
      if (wake_fire_s) begin
        irq_r <= 1'b1;
      end else if (irq_ack) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign rsp_status = rsp_status_r;
  assign rsp_count  = rsp_count_r;
  assign wake_task  = wake_task_r;
  assign wake_sem   = wake_sem_r;
  assign irq        = irq_r;

endmodule

// File: doc/semaphore_core.md
SEMAPHORE_CORE -- requirements
Module: semaphore_core

Interface
REQ-001 SHALL have parameter NUM_SEM, default 4, number of counting semaphores.
REQ-002 SHALL have parameter CNT_W, default 8, count width.
REQ-003 SHALL have parameter NUM_TASK, default 16, number of task IDs; TASK_W = clog2(NUM_TASK).
REQ-004 SHALL have port ACLK, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port ARESET, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), command handshake from the AXI4-Lite register slave.
REQ-007 SHALL have ports cmd_op (input, 2, INIT/TAKE/GIVE/QUERY), cmd_sem (input, clog2(NUM_SEM)), cmd_task (input, TASK_W) and cmd_data (input, CNT_W, INIT value).
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_status (output, 2, OK/BLOCKED/OVERFLOW) and rsp_count (output, CNT_W, post-operation count).
REQ-009 SHALL have ports wake_valid (output, 1), wake_ready (input, 1), wake_task (output, TASK_W) and wake_sem (output, clog2(NUM_SEM)), the task-release event.
REQ-010 SHALL have ports irq (output, 1, sticky) and irq_ack (input, 1, one-cycle clear).

Function
REQ-011 SHALL use FSM states IDLE, EXEC, RESP, WAKE; cmd_ready=1 only in IDLE.
REQ-012 IDLE->EXEC SHALL occur on cmd_valid&&cmd_ready; command fields SHALL be registered at acceptance.
REQ-013 EXEC SHALL last exactly one cycle, updating state; rsp_valid SHALL rise the cycle after EXEC (acceptance at N -> rsp_valid at N+2).
REQ-014 RESP SHALL hold rsp_valid and all rsp fields stable until rsp_ready; then go to WAKE if a handoff occurred, else IDLE.
REQ-015 WAKE SHALL hold wake_valid and wake fields stable until wake_ready, then return to IDLE.
REQ-016 INIT SHALL set count[sem]=cmd_data and max[sem]=cmd_data, clear waiters[sem], and return OK; cmd_data=0 SHALL be legal.
REQ-017 TAKE with count>0 SHALL decrement count and return OK.
REQ-018 TAKE with count=0 SHALL set waiters[sem][task], leave count unchanged, and return BLOCKED; a repeat TAKE from an already-waiting task SHALL return BLOCKED with no state change.
REQ-019 GIVE with waiters[sem]!=0 SHALL leave count unchanged, clear the lowest-index waiter bit, latch that task as wake_task, and return OK (handoff).
REQ-020 GIVE with no waiters and count<max SHALL increment count and return OK.
REQ-021 GIVE with no waiters and count=max SHALL return OVERFLOW and leave count unchanged; count SHALL never wrap.
REQ-022 QUERY SHALL return the current count with OK and no state change.
REQ-023 irq SHALL set on the wake_valid&&wake_ready cycle and clear on irq_ack; if both occur in the same cycle, set SHALL win.
REQ-024 Only one command SHALL be in flight; no command is accepted during EXEC, RESP or WAKE.

Reset
REQ-025 ARESET SHALL, in one cycle from any state, force FSM=IDLE, all counts, maxes and waiter bits=0, and irq=0.
REQ-026 ARESET SHALL force cmd_ready=0, rsp_valid=0, wake_valid=0, rsp_status=OK, rsp_count=0, wake_task=0 and wake_sem=0 during reset.
REQ-027 An in-flight response or wake SHALL be discarded by reset and not reissued; cmd_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-028 Package semaphore_pkg SHALL hold the op enum, status enum, FSM state enum, and NUM_SEM/CNT_W/NUM_TASK defaults.
REQ-029 Sub-module semaphore_prio_enc SHALL give the lowest set bit index and a found flag for a NUM_TASK-bit mask, combinationally.
REQ-030 Per-semaphore count, max and waiter arrays SHALL be flops, not RAM.

Verification
REQ-031 INIT sem0=2, then TAKE x3 (tasks 1,2,3) -> OK count1, OK count0, BLOCKED count0 with waiters[0]=0x0008.
REQ-032 Following REQ-031, GIVE sem0 task1 -> OK count0; wake_task=3, wake_sem=0; irq=1; waiters[0]=0; irq_ack -> irq=0.
REQ-033 INIT sem1=1, then GIVE -> OVERFLOW count1; QUERY -> OK count1.
REQ-034 Hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout; response completes on the first rsp_ready cycle.
REQ-035 Block tasks 5 and 2 on sem2, then GIVE twice -> wake order task2 then task5; irq_ack on the same cycle as a wake handshake -> irq stays 1.
REQ-036 Assert ARESET during RESP with count=3 -> rsp_valid=0 next cycle, QUERY returns count0, and no wake is issued.
